// File: rtl/beat_timing_gen.sv
// ---------------------------------------------------------------------------
// beat_timing_gen
//
// Timing front end for the hardwired controller. Each beat is split into
// three one-clock phases, T1 -> T2 -> T3. The block steps through beats
// W1/W2/W3 and drives the controller's W[3:1] and T3 inputs.
//
// The controller's SHORT/LONG/STOP flags are sampled only on the edge that
// leaves T3. That edge chooses the next beat and decides whether to keep
// running or to halt. A console START press (re)starts sequencing from idle.
//
// Optional build feature:
//   SINGLE_STEP_EN - adds the STEP_MODE input. When STEP_MODE is high at the
//                    end of a beat, it halts just like STOP. Each START press
//                    then runs exactly one beat.
//
// Parameters:
//   SYNC_STAGES  flip-flop stages on the asynchronous START pin (>= 2)
//   BEAT_CNT_W   width of the completed-beat debug counter
//
// Ports:
//   CLK        master clock, rising-edge active
//   CLR        synchronous active-low reset
//   START      console start button, asynchronous, active-high
//   SHORT      controller: after W1, go straight back to W1
//   LONG       controller: after W2, insert W3
//   STOP       controller: halt once the current beat completes
//   STEP_MODE  (SINGLE_STEP_EN only) halt after every beat
//   T1/T2/T3   phase strobes, one-hot while running, all low when idle
//   W[3:1]     one-hot current beat, W[1]=W1 .. W[3]=W3
//   RUN        high while beats are being sequenced
//   BEATS      completed-beat count, wraps
// ---------------------------------------------------------------------------
module beat_timing_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int BEAT_CNT_W  = 16
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  START,
  input  logic                  SHORT,
  input  logic                  LONG,
  input  logic                  STOP,
`ifdef SINGLE_STEP_EN
  input  logic                  STEP_MODE,
`endif
  output logic                  T1,
  output logic                  T2,
  output logic                  T3,
  output logic [3:1]            W,
  output logic                  RUN,
  output logic [BEAT_CNT_W-1:0] BEATS
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH1  = 2'd1,
    PH2  = 2'd2,
    PH3  = 2'd3
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] start_sync;
  logic                   start_prev;
  logic                   start_level;
  logic                   start_rise;
  logic                   halt_req;
  logic [3:1]             w_next;

  // START is asynchronous, so it first passes through a plain shift-register
  // synchroniser. start_prev holds the previous synchronised level. It is
  // updated on every clock, including while running. As a result, an edge
  // that arrives while running (or on the edge that drops into IDLE) is
  // consumed and never replayed later. A button held down therefore
  // produces only one rising edge.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      start_sync <= '0;
      start_prev <= 1'b0;
    end else begin
      start_sync <= {start_sync[SYNC_STAGES-2:0], START};
      start_prev <= start_level;
    end
  end

  assign start_level = start_sync[SYNC_STAGES-1];
  assign start_rise  = start_level & ~start_prev;

  // Next-beat selection and the halt request. These only matter on the
  // edge that leaves PH3. Their results land in registers, so the
  // controller flags never reach an output combinationally. An illegal
  // W code falls back to W1.
  always_comb begin
    w_next   = 3'b001;
    halt_req = STOP;
`ifdef SINGLE_STEP_EN
    halt_req = STOP | STEP_MODE;
`endif
    case (W)
      3'b001:  w_next = SHORT ? 3'b001 : 3'b010;
      3'b010:  w_next = LONG  ? 3'b100 : 3'b001;
      default: w_next = 3'b001;
    endcase
  end

  // Phase sequencer. Every output is registered alongside the state.
  // In PH3, W and BEATS update on the same edge that drops T3.
  // That edge also either re-enters PH1 or parks in IDLE.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state <= IDLE;
      RUN   <= 1'b0;
      W     <= 3'b001;
      T1    <= 1'b0;
      T2    <= 1'b0;
      T3    <= 1'b0;
      BEATS <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_rise) begin
            state <= PH1;
            RUN   <= 1'b1;
            T1    <= 1'b1;
          end
        end
        PH1: begin
          state <= PH2;
          T1    <= 1'b0;
          T2    <= 1'b1;
        end
        PH2: begin
          state <= PH3;
          T2    <= 1'b0;
          T3    <= 1'b1;
        end
        PH3: begin
          T3    <= 1'b0;
          W     <= w_next;
          BEATS <= BEATS + BEAT_CNT_W'(1);
          if (halt_req) begin
            state <= IDLE;
            RUN   <= 1'b0;
          end else begin
            state <= PH1;
            T1    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          RUN   <= 1'b0;
          T1    <= 1'b0;
          T2    <= 1'b0;
          T3    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beat_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_beat_timing_gen
//
// Randomised self-checking bench for beat_timing_gen.
//
// The stimulus side presses START and picks SHORT/LONG/STOP for each beat.
// For every beat it expects the DUT to run, it pushes the expected W, BEATS
// and start cycle into a queue. The expected values come from the beat
// rules, evaluated on a small integer beat model.
//
// The monitor side pops one entry each time T1 appears. It compares that
// entry against the DUT and then follows the T2/T3 phases of the beat.
//
// Define SINGLE_STEP_EN to also exercise STEP_MODE.
// ---------------------------------------------------------------------------
module tb_beat_timing_gen;

  localparam int SYNC_STAGES = 2;
  localparam int BEAT_CNT_W  = 16;
  localparam int BEAT_MASK   = (1 << BEAT_CNT_W) - 1;

  typedef struct {
    int w;
    int beats;
    int cyc;
  } exp_t;

  logic                  CLK;
  logic                  CLR;
  logic                  START;
  logic                  SHORT;
  logic                  LONG;
  logic                  STOP;
  logic                  step_mode;
  logic                  T1;
  logic                  T2;
  logic                  T3;
  logic [3:1]            W;
  logic                  RUN;
  logic [BEAT_CNT_W-1:0] BEATS;

  int   checks;
  int   failures;
  int   cyc;
  int   m_w;
  int   m_beats;
  logic abort_pending;
  exp_t exp_q[$];

  beat_timing_gen #(
    .SYNC_STAGES(SYNC_STAGES),
    .BEAT_CNT_W (BEAT_CNT_W)
  ) dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .START    (START),
    .SHORT    (SHORT),
    .LONG     (LONG),
    .STOP     (STOP),
`ifdef SINGLE_STEP_EN
    .STEP_MODE(step_mode),
`endif
    .T1       (T1),
    .T2       (T2),
    .T3       (T3),
    .W        (W),
    .RUN      (RUN),
    .BEATS    (BEATS)
  );

  // Free-running 10-unit clock, plus a count of rising edges that is used
  // to timestamp beats.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Hard stop in case the run never reaches its summary.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Beat rules: W1 -> W1 if SHORT, else W2; W2 -> W3 if LONG, else W1;
  // W3 -> W1.
  function automatic int next_beat(input int w, input logic s, input logic l);
    if (w == 1) return s ? 1 : 2;
    if (w == 2) return l ? 3 : 1;
    return 1;
  endfunction

  function automatic logic [2:0] w_code(input int w);
    return 3'(1 << (w - 1));
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_run"},   32'(RUN), 0);
    checkOutput({tag, "_t"},     32'({T1, T2, T3}), 0);
    checkOutput({tag, "_w"},     32'(W), 32'(w_code(m_w)));
    checkOutput({tag, "_beats"}, 32'(BEATS), m_beats & BEAT_MASK);
  endtask

  task automatic resetDut();
    CLR   = 1'b0;
    START = 1'b0;
    SHORT = 1'b0;
    LONG  = 1'b0;
    STOP  = 1'b0;
    tick();
    tick();
    m_w     = 1;
    m_beats = 0;
    checkIdle("in_reset");
    CLR = 1'b1;
    tick();
    checkIdle("after_reset");
  endtask

  // Presses START and plays n_beats beats.
  //
  // mode selects the controller flags:
  //   0 = all low
  //   1 = random
  //   2 = SHORT high
  //   3 = LONG high
  //
  // The last beat asserts STOP, unless STEP_MODE is doing the halting.
  //
  // opts:
  //   [0] pulse START during beat 1
  //   [1] hold START for 50 clocks
  //   [2] time a START edge onto the halting edge
  //   [3] reset during PH2 of the last beat
  task automatic applyStimulus(input int n_beats, input int mode, input logic [3:0] opts);
    int   first_cyc;
    int   held;
    logic s;
    logic l;
    logic st;
    logic last;
    logic aborted;
    exp_t e;

    aborted   = 1'b0;
    START     = 1'b1;
    first_cyc = cyc + SYNC_STAGES + 1;
    held      = 0;
    repeat (SYNC_STAGES + 1) begin
      tick();
      held++;
    end
    if (!opts[1]) START = 1'b0;

    for (int b = 0; b < n_beats; b++) begin
      last = (b == n_beats - 1);
      case (mode)
        0:       begin s = 1'b0; l = 1'b0; end
        2:       begin s = 1'b1; l = 1'($urandom_range(0, 1)); end
        3:       begin s = 1'b0; l = 1'b1; end
        default: begin s = 1'($urandom_range(0, 1)); l = 1'($urandom_range(0, 1)); end
      endcase
      st    = last && !opts[3] && !step_mode;
      SHORT = s;
      LONG  = l;
      STOP  = st;

      e.w     = m_w;
      e.beats = m_beats;
      e.cyc   = first_cyc + 3 * b;
      exp_q.push_back(e);

      if (opts[0] && b == 1) START = 1'b1;
      if (opts[0] && b == 2) START = 1'b0;
      if (opts[2] && last)   START = 1'b1;
      tick();
      held++;
      if (opts[2] && last) START = 1'b0;

      if (opts[3] && last) begin
        abort_pending = 1'b1;
        CLR = 1'b0;
        tick();
        m_w     = 1;
        m_beats = 0;
        checkIdle("abort");
        CLR = 1'b1;
        tick();
        abort_pending = 1'b0;
        aborted       = 1'b1;
        break;
      end

      tick();
      tick();
      held += 2;
      m_beats++;
      m_w = next_beat(m_w, s, l);
    end

    SHORT = 1'b0;
    LONG  = 1'b0;
    STOP  = 1'b0;
    if (opts[1]) begin
      while (held < 50) begin
        tick();
        held++;
      end
      START = 1'b0;
    end
    if (!aborted) begin
      repeat (6) tick();
      checkIdle("halted");
    end
  endtask

  // Scoreboard monitor.
  //
  // Each T1 pops one expected beat. The monitor then follows that beat's
  // T2 and T3 phases. A T2 or T3 seen outside a beat is reported on its own.
  initial begin : monitor
    exp_t e;
    logic have_e;
    forever begin
      @(negedge CLK);
      if (T1 === 1'b1) begin
        have_e = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_beat: T1 high at cycle %0d with W=%b, required no beat", cyc, W);
        end else begin
          e      = exp_q.pop_front();
          have_e = 1'b1;
          checkOutput("beat_w",     32'(W), 32'(w_code(e.w)));
          checkOutput("beat_count", 32'(BEATS), e.beats & BEAT_MASK);
          checkOutput("beat_cycle", cyc, e.cyc);
          checkOutput("beat_run",   32'(RUN), 1);
          checkOutput("ph1_t",      32'({T1, T2, T3}), 32'h4);
        end
        @(negedge CLK);
        if (!abort_pending) begin
          checkOutput("ph2_t", 32'({T1, T2, T3}), 32'h2);
          if (have_e) checkOutput("ph2_w", 32'(W), 32'(w_code(e.w)));
        end
        @(negedge CLK);
        if (!abort_pending) begin
          checkOutput("ph3_t", 32'({T1, T2, T3}), 32'h1);
          if (have_e) checkOutput("ph3_w", 32'(W), 32'(w_code(e.w)));
        end
      end else if (T2 === 1'b1 || T3 === 1'b1) begin
        checks++;
        failures++;
        $display("[TB] FAIL stray_phase: T=%b outside a beat at cycle %0d, required 000", {T1, T2, T3}, cyc);
      end
    end
  end

  initial begin
    checks        = 0;
    failures      = 0;
    abort_pending = 1'b0;
    step_mode     = 1'b0;
    m_w           = 1;
    m_beats       = 0;
    CLR           = 1'b0;
    START         = 1'b0;
    SHORT         = 1'b0;
    LONG          = 1'b0;
    STOP          = 1'b0;

    $display("[TB] reset and plain W1/W2 alternation");
    resetDut();
    applyStimulus(4, 0, 4'b0000);

    $display("[TB] SHORT keeps W1, then LONG inserts W3 and STOP parks there");
    applyStimulus(3, 2, 4'b0000);
    applyStimulus(2, 3, 4'b0000);

    $display("[TB] resume from W3, START pressed while running");
    applyStimulus(3, 0, 4'b0001);

    $display("[TB] START held 50 clocks, and START edge on the halting edge");
    applyStimulus(1, 1, 4'b0010);
    applyStimulus(2, 1, 4'b0100);

    $display("[TB] random beat runs");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(int'($urandom_range(2, 7)), 1, 4'b0000);
    end

    $display("[TB] reset during PH2 of W3");
    resetDut();
    applyStimulus(3, 3, 4'b1000);
    repeat (4) tick();
    checkIdle("post_abort");

`ifdef SINGLE_STEP_EN
    $display("[TB] single-step mode");
    step_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 4'b0000);
    end
    step_mode = 1'b0;
`endif

    repeat (10) tick();
    checkOutput("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
